// File: rtl/comp_chain.sv
// Word-level magnitude comparator fed MSB-first by a 2-bit slice comparator.
// Optional one-hot slice checking is compiled in with COMP_CHAIN_ONEHOT_CHECK_EN.
module comp_chain #(
    parameter int NSLICES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic slice_valid,
    input  logic eq,
    input  logic gt,
    input  logic lt,
    output logic busy,
    output logic done,
    output logic a_eq_b,
    output logic a_gt_b,
    output logic a_lt_b,
    output logic error
);

    localparam int CW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ,
        RES_GT,
        RES_LT
    } res_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          decided_reg, decided_next;
    res_t          res_reg, res_next;
    logic          busy_reg, done_reg;
    logic          eq_reg, gt_reg, lt_reg;
    logic          load_result;

`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
    logic err_reg, err_next, err_out_reg, slice_bad;

    // Any slice that is not exactly one-hot, including all-zero, is flagged.
    always_comb begin
        slice_bad = 1'b1;
        case ({eq, gt, lt})
            3'b100, 3'b010, 3'b001: slice_bad = 1'b0;
            default:                slice_bad = 1'b1;
        endcase
    end
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        decided_next = decided_reg;
        res_next     = res_reg;
`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
        err_next     = err_reg;
`endif
        unique case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = SCAN;
                    cnt_next     = '0;
                    decided_next = 1'b0;
                    res_next     = RES_EQ;
`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
                    err_next     = 1'b0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                if (slice_valid) begin
                    // The first non-equal slice from the MSB end decides the word.
                    if (!decided_reg) begin
                        casez ({gt, lt, eq})
                            3'b1??: begin
                                res_next     = RES_GT;
                                decided_next = 1'b1;
                            end
                            3'b01?: begin
                                res_next     = RES_LT;
                                decided_next = 1'b1;
                            end
                            default: res_next = res_reg;
                        endcase
                    end
`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
                    err_next = err_reg | slice_bad;
`endif
                    if (cnt_reg == LAST) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results include the final slice, so they are taken from the next-state values.
    assign load_result = (state_reg == SCAN) && (state_next == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            decided_reg <= 1'b0;
            res_reg     <= RES_EQ;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            eq_reg      <= 1'b0;
            gt_reg      <= 1'b0;
            lt_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            decided_reg <= decided_next;
            res_reg     <= res_next;
            busy_reg    <= (state_next == SCAN);
            done_reg    <= load_result;
            if (load_result) begin
                eq_reg <= (res_next == RES_EQ);
                gt_reg <= (res_next == RES_GT);
                lt_reg <= (res_next == RES_LT);
            end
        end
    end

`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_reg     <= 1'b0;
            err_out_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (load_result) begin
                err_out_reg <= err_next;
            end
        end
    end

    assign error = err_out_reg;
`else
    assign error = 1'b0;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign a_eq_b = eq_reg;
    assign a_gt_b = gt_reg;
    assign a_lt_b = lt_reg;

endmodule

// File: tb/tb_comp_chain.sv
// Self-checking bench for comp_chain: directed scenarios plus randomized word compares.
module tb_comp_chain;

    localparam int NS = 4;
`ifdef COMP_CHAIN_ONEHOT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic slice_valid = 1'b0;
    logic eq = 1'b0, gt = 1'b0, lt = 1'b0;
    logic busy, done, a_eq_b, a_gt_b, a_lt_b, error;

    int checks = 0;
    int errors = 0;

    bit s_eq [NS];
    bit s_gt [NS];
    bit s_lt [NS];

    comp_chain #(.NSLICES(NS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .slice_valid(slice_valid),
        .eq(eq), .gt(gt), .lt(lt), .busy(busy), .done(done),
        .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .error(error)
    );

    always #5 clk = ~clk;

    // Load slices from two words, MSB slice first, as the upstream comparator would.
    task automatic load_words(input logic [2*NS-1:0] a, input logic [2*NS-1:0] b);
        for (int i = 0; i < NS; i++) begin
            logic [1:0] sa, sb;
            sa = a[2*(NS-1-i) +: 2];
            sb = b[2*(NS-1-i) +: 2];
            s_eq[i] = (sa == sb);
            s_gt[i] = (sa > sb);
            s_lt[i] = (sa < sb);
        end
    endtask

    task automatic set_slices(input logic [2:0] k0, input logic [2:0] k1,
                              input logic [2:0] k2, input logic [2:0] k3);
        logic [2:0] k [NS];
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        for (int i = 0; i < NS; i++) begin
            s_eq[i] = k[i][2];
            s_gt[i] = k[i][1];
            s_lt[i] = k[i][0];
        end
    endtask

    // Drives one comparison; returns observations only, callers compare.
    task automatic run_op(input bit do_start, input int gap_pos, input int gap_len,
                          input bit pulse_start, input bit start_in_done,
                          output int lat, output int npulses, output logic [3:0] res,
                          output logic busy_first, output logic busy_after);
        int cyc;
        cyc = 0; lat = 0; npulses = 0;
        if (do_start) begin
            start = 1'b1; slice_valid = 1'b0;
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            if (done) npulses++;
        end
        busy_first = busy;
        for (int i = 0; i < NS; i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    slice_valid = 1'b0;
                    start = pulse_start;
                    eq = 1'($urandom); gt = 1'($urandom); lt = 1'($urandom);
                    @(posedge clk); cyc++; #1;
                    start = 1'b0;
                    if (done) begin npulses++; if (lat == 0) lat = cyc; end
                end
            end
            slice_valid = 1'b1;
            start = pulse_start && (i == 1);
            eq = s_eq[i]; gt = s_gt[i]; lt = s_lt[i];
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            if (done) begin npulses++; if (lat == 0) lat = cyc; end
        end
        res = {a_eq_b, a_gt_b, a_lt_b, error};
        slice_valid = 1'b0;
        start = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        busy_after = busy;
        if (done) npulses++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) begin
            start = 1'($urandom); slice_valid = 1'($urandom);
            eq = 1'($urandom); gt = 1'($urandom); lt = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
        end
        checks++;
        if ({a_eq_b, a_gt_b, a_lt_b, error} !== 4'b0000) begin
            errors++; $display("FAIL reset_results got=%b exp=0000", {a_eq_b, a_gt_b, a_lt_b, error});
        end
        start = 1'b0; slice_valid = 1'b0; eq = 1'b0; gt = 1'b0; lt = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_release_idle got=%b exp=00", {busy, done});
        end
        $display("test_reset: busy=%b done=%b", busy, done);
    endtask

    task automatic test_gt_mid();
        int lat, np; logic [3:0] res; logic bf, ba;
        load_words(8'hB4, 8'hB1);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_gt_mid: lat=%0d pulses=%0d res=%b", lat, np, res);
        checks++;
        if (bf !== 1'b1) begin errors++; $display("FAIL gt_mid_busy got=%b exp=1", bf); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL gt_mid_latency got=%0d exp=5", lat); end
        checks++;
        if (res !== 4'b0100) begin errors++; $display("FAIL gt_mid_result got=%b exp=0100", res); end
        checks++;
        if (np !== 1 || ba !== 1'b0) begin
            errors++; $display("FAIL gt_mid_pulse got=%0d/%b exp=1/0", np, ba);
        end
    endtask

    task automatic test_early_decision();
        int lat, np; logic [3:0] res; logic bf, ba;
        set_slices(3'b001, 3'b010, 3'b010, 3'b010);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_early_lt: lat=%0d res=%b", lat, res);
        checks++;
        if (res !== 4'b0010) begin errors++; $display("FAIL early_lt_result got=%b exp=0010", res); end
        set_slices(3'b100, 3'b100, 3'b100, 3'b100);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_all_eq: lat=%0d res=%b", lat, res);
        checks++;
        if (res !== 4'b1000) begin errors++; $display("FAIL all_eq_result got=%b exp=1000", res); end
    endtask

    task automatic test_gaps_start();
        int lat, np; logic [3:0] res; logic bf, ba;
        set_slices(3'b100, 3'b010, 3'b100, 3'b100);
        run_op(1'b1, 2, 3, 1'b1, 1'b1, lat, np, res, bf, ba);
        $display("test_gaps_start: lat=%0d pulses=%0d res=%b busy_after=%b", lat, np, res, ba);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL gaps_latency got=%0d exp=8", lat); end
        checks++;
        if (res !== 4'b0100) begin errors++; $display("FAIL gaps_result got=%b exp=0100", res); end
        checks++;
        if (ba !== 1'b1) begin errors++; $display("FAIL gaps_start_in_done_busy got=%b exp=1", ba); end
        // Finish the comparison opened by holding start through DONE.
        set_slices(3'b100, 3'b100, 3'b100, 3'b100);
        run_op(1'b0, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_gaps_followup: lat=%0d res=%b", lat, res);
        checks++;
        if (lat !== NS || res !== 4'b1000) begin
            errors++; $display("FAIL gaps_followup got=%0d/%b exp=%0d/1000", lat, res, NS);
        end
    endtask

    task automatic test_back_to_back();
        int lat, np; logic [3:0] res; logic bf, ba;
        set_slices(3'b100, 3'b100, 3'b001, 3'b010);
        run_op(1'b1, NS, 0, 1'b0, 1'b1, lat, np, res, bf, ba);
        $display("test_b2b_first: lat=%0d res=%b busy_after=%b", lat, res, ba);
        checks++;
        if (res !== 4'b0010 || ba !== 1'b1) begin
            errors++; $display("FAIL b2b_first got=%b/%b exp=0010/1", res, ba);
        end
        set_slices(3'b010, 3'b001, 3'b100, 3'b100);
        run_op(1'b0, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_b2b_second: lat=%0d res=%b", lat, res);
        checks++;
        if (lat !== NS || res !== 4'b0100) begin
            errors++; $display("FAIL b2b_second got=%0d/%b exp=%0d/0100", lat, res, NS);
        end
    endtask

    task automatic test_onehot();
        int lat, np; logic [3:0] res; logic bf, ba;
        set_slices(3'b110, 3'b100, 3'b100, 3'b100);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_onehot_bad: res=%b", res);
        checks++;
        if (res !== {3'b010, ERR_EN}) begin
            errors++; $display("FAIL onehot_bad got=%b exp=%b", res, {3'b010, ERR_EN});
        end
        // Error still accumulates after the decision; all-zero counts as bad.
        set_slices(3'b001, 3'b000, 3'b100, 3'b100);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_onehot_late: res=%b", res);
        checks++;
        if (res !== {3'b001, ERR_EN}) begin
            errors++; $display("FAIL onehot_late got=%b exp=%b", res, {3'b001, ERR_EN});
        end
        set_slices(3'b100, 3'b100, 3'b100, 3'b100);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_onehot_clean: res=%b", res);
        checks++;
        if (res !== 4'b1000) begin errors++; $display("FAIL onehot_clean got=%b exp=1000", res); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, np; logic [3:0] res; logic bf, ba;
        int seen;
        seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            slice_valid = 1'b1; eq = 1'b1; gt = 1'b0; lt = 1'b0;
            @(posedge clk); #1;
            if (done) seen++;
        end
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if ({busy, done, a_eq_b, a_gt_b, a_lt_b, error} !== 6'b0 || seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_scan got=%b done_seen=%0d exp=000000/0",
                     {busy, done, a_eq_b, a_gt_b, a_lt_b, error}, seen);
        end
        slice_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_slices(3'b100, 3'b100, 3'b100, 3'b100);
        run_op(1'b1, NS, 0, 1'b0, 1'b0, lat, np, res, bf, ba);
        $display("test_reset_mid_scan: lat=%0d res=%b", lat, res);
        checks++;
        if (lat !== NS + 1 || res !== 4'b1000) begin
            errors++; $display("FAIL post_reset_cmp got=%0d/%b exp=%0d/1000", lat, res, NS + 1);
        end
    endtask

    task automatic test_random();
        int lat, np, gp, gl, exp_lat; logic [3:0] res, exp_res; logic bf, ba;
        logic [2*NS-1:0] a, b;
        for (int t = 0; t < 24; t++) begin
            a = (2*NS)'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : (2*NS)'($urandom);
            gp = $urandom_range(0, NS);
            gl = (gp < NS) ? $urandom_range(0, 3) : 0;
            load_words(a, b);
            exp_res = {a == b, a > b, a < b, 1'b0};
            exp_lat = 1 + NS + gl;
            run_op(1'b1, gp, gl, 1'($urandom), 1'b0, lat, np, res, bf, ba);
            $display("test_random[%0d]: a=%h b=%h gap=%0d@%0d lat=%0d res=%b", t, a, b, gl, gp, lat, res);
            checks++;
            if (res !== exp_res || lat !== exp_lat || np !== 1) begin
                errors++;
                $display("FAIL random_%0d got=%b/%0d/%0d exp=%b/%0d/1", t, res, lat, np, exp_res, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gt_mid();
        test_early_decision();
        test_gaps_start();
        test_back_to_back();
        test_onehot();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
